// File: rtl/tx_frame_sender_if.sv
// tx_frame_sender_if: producer, frame-command and UART-transmitter signals of tx_frame_sender
//   wr_en/wr_data        producer push into the payload FIFO
//   full/count           FIFO occupancy
//   frame_go/frame_len   frame start request and payload length
//   busy/frame_done/go_err  frame status
//   TX_Data/Send_Sig     byte and request level toward the transmitter
//   TX_Done_Sig          transmitter byte-complete pulse
//   master: the side issuing pushes/commands and acting as transmitter; slave: the framer
interface tx_frame_sender_if #(parameter int DEPTH = 16);
   localparam int CW = $clog2(DEPTH) + 1;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic [CW-1:0] count;
   logic          frame_go;
   logic [CW-1:0] frame_len;
   logic          busy;
   logic          frame_done;
   logic          go_err;
   logic [7:0]    TX_Data;
   logic          Send_Sig;
   logic          TX_Done_Sig;
   modport master (
      output wr_en, wr_data, frame_go, frame_len, TX_Done_Sig,
      input  full, count, busy, frame_done, go_err, TX_Data, Send_Sig
   );
   modport slave (
      input  wr_en, wr_data, frame_go, frame_len, TX_Done_Sig,
      output full, count, busy, frame_done, go_err, TX_Data, Send_Sig
   );
endinterface

// File: rtl/tx_frame_sender.sv
// tx_frame_sender: buffers payload bytes and sends header + payload + additive checksum frames to a UART transmitter
//   CLK   system clock, rising edge
//   RSTn  asynchronous active-low reset
//   bus   tx_frame_sender_if.slave: FIFO push, frame command/status, transmitter handshake
module tx_frame_sender #(
   parameter int         DEPTH  = 16,
   parameter logic [7:0] HEADER = 8'hAA
) (
   input logic CLK,
   input logic RSTn,
   tx_frame_sender_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   typedef enum logic [1:0] {HDR, PAY, SUM} phase_t;
   state_t        state, state_nx;
   phase_t        phase, phase_nx;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt, rem;
   logic [7:0]    sum, tx_data, byte_nx;
   logic          push, pop, go_ok, done_b, load, done_r, err_r;
   assign push   = bus.wr_en && !bus.full;
   assign done_b = state == SEND && bus.TX_Done_Sig;
   assign pop    = done_b && phase == PAY;
   assign go_ok  = bus.frame_go && state == IDLE && bus.frame_len != '0 &&
                   bus.frame_len <= CW'(DEPTH) && cnt >= bus.frame_len;
   // In GAP the pop and checksum update of the previous byte have already landed,
   // so the FIFO head and sum register are the correct next byte.
   assign byte_nx = phase_nx == HDR ? HEADER : phase_nx == PAY ? mem[rp] : sum;
   always_comb begin
      state_nx = state;
      phase_nx = phase;
      load     = 1'b0;
      case (state)
         IDLE: if (go_ok) begin
            state_nx = SEND;
            phase_nx = HDR;
            load     = 1'b1;
         end
         // The checksum byte returns straight to IDLE so a new frame_go is accepted
         // the cycle frame_done is seen.
         SEND: if (bus.TX_Done_Sig) state_nx = phase == SUM ? IDLE : GAP;
         GAP: begin
            state_nx = SEND;
            phase_nx = (phase == HDR || rem != '0) ? PAY : SUM;
            load     = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) begin
         state <= IDLE;
         phase <= HDR;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
      end
   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         rem     <= '0;
         sum     <= 8'h00;
         tx_data <= 8'h00;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         wp      <= wp + AW'(push);
         rp      <= rp + AW'(pop);
         cnt     <= cnt + CW'(push) - CW'(pop);
         rem     <= go_ok ? bus.frame_len : pop ? rem - 1'b1 : rem;
         sum     <= go_ok ? 8'h00 : pop ? sum + tx_data : sum;
         tx_data <= load ? byte_nx : tx_data;
         done_r  <= done_b && phase == SUM;
         err_r   <= bus.frame_go && !go_ok;
      end
   always_ff @(posedge CLK)
      if (push) mem[wp] <= bus.wr_data;
   assign bus.full       = cnt == CW'(DEPTH);
   assign bus.count      = cnt;
   assign bus.busy       = state != IDLE;
   assign bus.Send_Sig   = state == SEND;
   assign bus.TX_Data    = tx_data;
   assign bus.frame_done = done_r;
   assign bus.go_err     = err_r;
endmodule
